idct_tp_buffer: RTL and testbench
=================================

IDCT_TP_BUFFER -- requirements
Module: idct_tp_buffer

Interface
REQ-001 SHALL have parameter W, default 10, giving the signed coefficient lane width.
REQ-002 SHALL have clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 SHALL have reset, input, 1 bit; synchronous, active-high.
REQ-004 SHALL have in_data, input, 8*W bits; one 8x8-block row, lane k at bits [W*k+W-1:W*k] (lane 0 in the LSBs), where lane c of row r is coefficient (r,c).
REQ-005 SHALL have in_valid, input, 1 bit; the producer offers in_data.
REQ-006 SHALL have in_ready, output, 1 bit; the block can accept a row.
REQ-007 SHALL have out_data, output, 8*W bits; one block column, where lane k of column c is coefficient (k,c).
REQ-008 SHALL have out_valid, output, 1 bit; out_data is presented.
REQ-009 SHALL have out_ready, input, 1 bit; the consumer accepts out_data.
REQ-010 SHALL have out_last, output, 1 bit; out_data is column 7 of the current block.
REQ-011 SHALL have blk_cnt, output, 16 bits; the number of fully drained blocks, modulo 2^16.

Function
REQ-012 SHALL contain two 8x8xW storage banks operated ping-pong: the writer fills one bank while the reader drains the other.
REQ-013 SHALL keep state wr_bank, wr_row[2:0], rd_bank, rd_col[2:0] and full[1:0].
REQ-014 SHALL drive in_ready = ~full[wr_bank], combinationally from registers only, never from in_valid.
REQ-015 SHALL treat a row write as occurring on a clock edge where in_valid & in_ready: in_data is stored to bank[wr_bank] row wr_row, and wr_row increments.
REQ-016 SHALL, on the write with wr_row==7, set full[wr_bank], toggle wr_bank and wrap wr_row to 0.
REQ-017 SHALL drive out_valid = full[rd_bank] and out_last = out_valid & (rd_col==7).
REQ-018 SHALL drive out_data as column rd_col of bank[rd_bank] when out_valid is 1, and all-zero when out_valid is 0.
REQ-019 SHALL treat a column read as occurring on an edge where out_valid & out_ready: rd_col increments.
REQ-020 SHALL, on the read with rd_col==7, clear full[rd_bank], toggle rd_bank, wrap rd_col to 0 and increment blk_cnt (wrapping at 0xFFFF).
REQ-021 SHALL apply both updates when a write sets one full bit and a read clears the other on the same edge.
REQ-022 SHALL ignore in_data when in_valid is 0 or in_ready is 0, and SHALL ignore out_ready when out_valid is 0.
REQ-023 SHALL hold out_data, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL raise out_valid on the edge following acceptance of row 7 of a block, giving a latency of 1 cycle after the last row and 8 cycles from the first row at full rate.
REQ-025 SHALL sustain 1 row in and 1 column out per cycle indefinitely when in_valid=1 and out_ready=1.
REQ-026 SHALL deassert in_ready when both banks are full, and SHALL reassert it on the edge after the draining bank's column 7 is read.
REQ-027 SHALL pass values unmodified (pure transpose, no arithmetic), with sign bits carried unchanged.

Reset
REQ-028 SHALL, on any edge with reset=1, set full=0, wr_bank=0, wr_row=0, rd_bank=0, rd_col=0 and blk_cnt=0, giving in_ready=1, out_valid=0, out_last=0 and out_data=0.
REQ-029 SHALL leave storage contents not reset, since they are unobservable while out_valid=0.
REQ-030 SHALL, on reset mid-operation, discard partially written and full blocks without producing any output, and SHALL have reset override a simultaneous handshake.

Verification
REQ-031 SHALL cover single block: rows r=0..7 with lane c = 8r+c on consecutive cycles and out_ready=1 -> out_valid rises 1 cycle after row 7; column c lane k = 8k+c; out_last only on column 7; blk_cnt=1.
REQ-032 SHALL cover streaming: 4 back-to-back blocks with in_valid and out_ready held at 1 -> in_ready never drops; 32 columns out, correctly transposed per block; blk_cnt=4.
REQ-033 SHALL cover backpressure: out_ready=0 while 2 blocks are written -> in_ready=0 after 16 rows, and row 17 is not accepted; one out_ready=1 pulse advances exactly one column with out_data stable between pulses.
REQ-034 SHALL cover signed extremes: lanes set to -512 (0x200) and 511 (0x1FF) -> bit-exact transposition.
REQ-035 SHALL cover reset mid-block: reset asserted after 5 rows -> next cycle in_ready=1, out_valid=0; a subsequent full block is output correctly.
REQ-036 SHALL cover counter wrap: blk_cnt preloaded via 65536 drained blocks -> blk_cnt reads 0.

Source files
------------

// File: rtl/idct_tp_buffer.sv
// Ping-pong 8x8 transpose buffer between IDCT passes.
// Rows are written into one bank while columns drain from the other.
module idct_tp_buffer #(
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [8*W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [15:0]    blk_cnt
);

  logic [W-1:0] mem_q [2][8][8];

  logic        wr_bank_q, wr_bank_d;
  logic [2:0]  wr_row_q, wr_row_d;
  logic        rd_bank_q, rd_bank_d;
  logic [2:0]  rd_col_q, rd_col_d;
  logic [1:0]  full_q, full_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;

  logic wr_fire;
  logic rd_fire;
  logic wr_done;
  logic rd_done;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid & (rd_col_q == 3'd7);
  assign blk_cnt   = blk_cnt_q;

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_done = wr_fire & (wr_row_q == 3'd7);
  assign rd_done = rd_fire & (rd_col_q == 3'd7);

  // Storage is not reset; it is invisible until a bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[wr_bank_q][wr_row_q][c] <= in_data[W*c +: W];
      end
    end
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_done) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    blk_cnt_d = blk_cnt_q;
    if (rd_fire) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_done) begin
        rd_bank_d = ~rd_bank_q;
        blk_cnt_d = blk_cnt_q + 16'd1;
      end
    end
  end

  // Writer and reader always own different banks, so both edits compose.
  always_comb begin
    full_d = full_q;
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
      full_q    <= 2'b00;
      blk_cnt_q <= 16'd0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int k = 0; k < 8; k++) begin
        out_data[W*k +: W] = mem_q[rd_bank_q][k][rd_col_q];
      end
    end
  end

endmodule

// File: tb/tb_idct_tp_buffer.sv
// Directed bench for idct_tp_buffer: transpose, flow control,
// reset and counter behaviour.
module tb_idct_tp_buffer;

  localparam int W = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [8*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [15:0]    blk_cnt;

  int nvec = 0;
  int nerr = 0;

  idct_tp_buffer #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .blk_cnt  (blk_cnt)
  );

  always #5 clk = ~clk;

  // pat 99: alternating signed extremes; else distinct counting values
  function automatic logic [W-1:0] val(int pat, int r, int c);
    logic [31:0] v;
    if (pat == 99) begin
      v = ((r + c) % 2 == 1) ? 32'h1FF : 32'h200;
    end else begin
      v = pat * 64 + 8 * r + c;
    end
    return v[W-1:0];
  endfunction

  function automatic logic [8*W-1:0] row_vec(int pat, int r);
    logic [8*W-1:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[W*c +: W] = val(pat, r, c);
    return v;
  endfunction

  function automatic logic [8*W-1:0] col_vec(int pat, int c);
    logic [8*W-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[W*k +: W] = val(pat, k, c);
    return v;
  endfunction

  task automatic chk(string tag, logic [8*W-1:0] obs,
                     logic [8*W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_block(int pat);
    for (int r = 0; r < 8; r++) begin
      chk("wr_in_ready", 80'(in_ready), 80'(1));
      in_data = row_vec(pat, r);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(int pat, int c0);
    out_ready = 1'b1;
    for (int c = c0; c < 8; c++) begin
      chk("dr_valid", 80'(out_valid), 80'(1));
      chk("dr_data", out_data, col_vec(pat, c));
      chk("dr_last", 80'(out_last), 80'(c == 7));
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int ocnt;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_last", 80'(out_last), 80'(0));
    chk("rst_out_data", out_data, 80'(0));
    chk("rst_blk_cnt", 80'(blk_cnt), 80'(0));

    // single block, out_valid one cycle after row 7
    write_block(0);
    drain(0, 0);
    chk("sb_valid_off", 80'(out_valid), 80'(0));
    chk("sb_blk_cnt", 80'(blk_cnt), 80'(1));

    // four back-to-back blocks at full rate
    do_reset();
    out_ready = 1'b1;
    ocnt = 0;
    for (int n = 0; n < 42; n++) begin
      if (n < 32) begin
        chk("st_in_ready", 80'(in_ready), 80'(1));
        in_data = row_vec(1 + n / 8, n % 8);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("st_valid", 80'(out_valid), 80'(n >= 8 && n < 40));
      if (out_valid) begin
        chk("st_data", out_data, col_vec(1 + ocnt / 8, ocnt % 8));
        chk("st_last", 80'(out_last), 80'(ocnt % 8 == 7));
        ocnt++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("st_cols", 80'(ocnt), 80'(32));
    chk("st_blk_cnt", 80'(blk_cnt), 80'(4));

    // backpressure: 16 rows fill both banks, row 17 is refused
    do_reset();
    for (int n = 0; n < 18; n++) begin
      chk("bp_in_ready", 80'(in_ready), 80'(n < 16));
      in_data = (n < 16) ? row_vec(10 + n / 8, n % 8)
                         : row_vec(12, 0);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_col0", out_data, col_vec(10, 0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_pulse", out_data, col_vec(10, 1));
    @(negedge clk);
    @(negedge clk);
    chk("bp_hold", out_data, col_vec(10, 1));
    chk("bp_hold_v", 80'(out_valid), 80'(1));
    chk("bp_hold_last", 80'(out_last), 80'(0));
    chk("bp_still_full", 80'(in_ready), 80'(0));
    drain(10, 1);
    chk("bp_reopen", 80'(in_ready), 80'(1));
    drain(11, 0);
    chk("bp_blk_cnt", 80'(blk_cnt), 80'(2));

    // signed extremes, also proves refused row left wr_row alone
    write_block(99);
    drain(99, 0);

    // reset in the middle of a block, with a handshake pending
    for (int r = 0; r < 5; r++) begin
      in_data = row_vec(20, r);
      in_valid = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    chk("mr_in_ready", 80'(in_ready), 80'(1));
    chk("mr_out_valid", 80'(out_valid), 80'(0));
    chk("mr_out_data", out_data, 80'(0));
    chk("mr_blk_cnt", 80'(blk_cnt), 80'(0));
    write_block(5);
    drain(5, 0);
    chk("mr_blk_cnt1", 80'(blk_cnt), 80'(1));

    // counter wrap: preload the count to its last value
    force dut.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    @(negedge clk);
    chk("wr_pre", 80'(blk_cnt), 80'(16'hFFFF));
    write_block(6);
    drain(6, 0);
    chk("wr_wrap", 80'(blk_cnt), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
